// File: rtl/spi_led_top.sv
// SPI slave LED controller: 24-bit command frames set per-LED brightness registers,
// which drive one PWM output per LED. SPI inputs are synchronised into sysclk.
module spi_led_top #(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned FRAME_WIDTH = 24,
  parameter int unsigned PWM_BITS    = 7,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_NOP     = 8'h00,
  parameter logic [7:0]  CMD_LED_SET = 8'h01
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic led8
);

  localparam int unsigned CntW   = $clog2(FRAME_WIDTH + 1);
  localparam int unsigned AddrW  = $clog2(NUM_LEDS);
  localparam int unsigned PwmTop = (2 ** PWM_BITS) - 2;

  // Synchronisers plus one delayed copy for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, cs_dly_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall;

  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic [FRAME_WIDTH-1:0] tx_q, tx_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   rx_dv_q, rx_dv_d;
  logic                   miso_q, miso_d;

  logic [NUM_LEDS-1:0][PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0]               led_q, led_d;

  logic [7:0] cmd, addr;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  assign cmd  = frame_q[FRAME_WIDTH-1 -: 8];
  assign addr = frame_q[FRAME_WIDTH-9 -: 8];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  // Receive path. Holding the counter clear while cs is high also covers the cs falling edge.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    rx_dv_d   = 1'b0;
    if (cs_s || cs_fall) begin
      bit_cnt_d = '0;
    end else if (sclk_rise && (bit_cnt_q < CntW'(FRAME_WIDTH))) begin
      shift_d   = {shift_q[FRAME_WIDTH-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == CntW'(FRAME_WIDTH - 1)) begin
        frame_d = shift_d;
        rx_dv_d = 1'b1;
      end
    end
  end

  // Transmit path echoes the last complete frame; miso is registered from the next tx state
  // so the MSB appears as soon as the load happens.
  always_comb begin
    tx_d = tx_q;
    if (cs_fall) begin
      tx_d = frame_q;
    end else if (!cs_s && sclk_fall) begin
      tx_d = {tx_q[FRAME_WIDTH-2:0], 1'b0};
    end
    miso_d = ~cs_s & tx_d[FRAME_WIDTH-1];
  end

  always_comb begin
    bright_d = bright_q;
    if (rx_dv_q && (cmd == CMD_LED_SET) && (32'(addr) < NUM_LEDS)) begin
      bright_d[addr[AddrW-1:0]] = frame_q[PWM_BITS-1:0];
    end
  end

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_BITS'(PwmTop)) ? '0 : pwm_cnt_q + 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = pwm_cnt_q < bright_q[i];
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      shift_q     <= '0;
      frame_q     <= '0;
      tx_q        <= '0;
      bit_cnt_q   <= '0;
      rx_dv_q     <= 1'b0;
      miso_q      <= 1'b0;
      bright_q    <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_dv_q     <= rx_dv_d;
      miso_q      <= miso_d;
      bright_q    <= bright_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

  assign miso = miso_q;
  assign led1 = led_q[0];
  assign led2 = led_q[1];
  assign led3 = led_q[2];
  assign led4 = led_q[3];
  assign led5 = led_q[4];
  assign led6 = led_q[5];
  assign led7 = led_q[6];
  assign led8 = led_q[7];

endmodule

// File: tb/tb_spi_led_top.sv
// Directed bench for spi_led_top: SPI frames driven bit by bit, brightness, PWM duty,
// rx_dv pulse count and miso echo checked against hand-computed values.
module tb_spi_led_top;

  logic sysclk, rst_n, sclk, cs, mosi;
  logic miso, led1, led2, led3, led4, led5, led6, led7, led8;
  logic [7:0] leds;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int duty[8];
  logic [23:0] rx_word;

  spi_led_top dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso),
    .led1   (led1),
    .led2   (led2),
    .led3   (led3),
    .led4   (led4),
    .led5   (led5),
    .led6   (led6),
    .led7   (led7),
    .led8   (led8)
  );

  assign leds = {led8, led7, led6, led5, led4, led3, led2, led1};

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (dut.rx_dv_q === 1'b1) dv_cnt <= dv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Mode-0 transfer, 6 sysclk per sclk half period; miso sampled just before each rise.
  task automatic spi_xfer(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    rx = '0;
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[23-i];
      wait_cyc(6);
      rx = {rx[22:0], miso};
      sclk = 1'b1;
      wait_cyc(6);
      sclk = 1'b0;
    end
    wait_cyc(6);
    cs = 1'b1;
    mosi = 1'b0;
    wait_cyc(2);
  endtask

  task automatic measure();
    for (int i = 0; i < 8; i++) duty[i] = 0;
    repeat (127) begin
      @(negedge sysclk);
      for (int i = 0; i < 8; i++) duty[i] += int'(leds[i]);
    end
  endtask

  task automatic check_duty(input string tag, input int e0, input int e1, input int e3,
                            input int e7);
    measure();
    check({tag, "_led1"}, duty[0], e0);
    check({tag, "_led2"}, duty[1], e1);
    check({tag, "_led4"}, duty[3], e3);
    check({tag, "_led8"}, duty[7], e7);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);

    check("reset_leds", leds, 8'h00);
    check("reset_miso", miso, 1'b0);
    check("reset_bright", dut.bright_q, 56'h0);
    check_duty("reset_duty", 0, 0, 0, 0);

    // Frame 1: brightness[0] = 0x40
    spi_xfer(24'h010040, 24, rx_word);
    check("f1_miso", rx_word, 24'h000000);
    check("f1_dv", dv_cnt, 1);
    check("f1_b0", dut.bright_q[0], 7'h40);
    check_duty("f1_duty", 64, 0, 0, 0);

    // Frame 2: brightness[7] = 0x7F, echoes frame 1
    spi_xfer(24'h01077F, 24, rx_word);
    check("f2_miso", rx_word, 24'h010040);
    check("f2_dv", dv_cnt, 2);
    check("f2_b7", dut.bright_q[7], 7'h7F);
    check("f2_b0", dut.bright_q[0], 7'h40);
    check_duty("f2_duty", 64, 0, 0, 127);

    // Frame 3: out-of-range address, no change
    spi_xfer(24'h0110FF, 24, rx_word);
    check("f3_miso", rx_word, 24'h01077F);
    check("f3_dv", dv_cnt, 3);
    check("f3_bright", dut.bright_q, {7'h7F, 42'h0, 7'h40});

    // Frame 4: NOP, no change
    spi_xfer(24'h000000, 24, rx_word);
    check("f4_miso", rx_word, 24'h0110FF);
    check("f4_dv", dv_cnt, 4);
    check("f4_bright", dut.bright_q, {7'h7F, 42'h0, 7'h40});

    // Frame 5: brightness[3] = 0, miso echoes the NOP frame
    spi_xfer(24'h010300, 24, rx_word);
    check("f5_miso", rx_word, 24'h000000);
    check("f5_dv", dv_cnt, 5);
    check("f5_b3", dut.bright_q[3], 7'h00);
    check_duty("f5_duty", 64, 0, 0, 127);

    // Aborted after 12 bits: no rx_dv, no change, frame latch untouched
    spi_xfer(24'h010155, 12, rx_word);
    check("abort_miso", rx_word, 24'h000010);
    check("abort_dv", dv_cnt, 5);
    check("abort_b1", dut.bright_q[1], 7'h00);
    check("abort_miso_idle", miso, 1'b0);

    // Full retransmission after the abort
    spi_xfer(24'h010155, 24, rx_word);
    check("retx_miso", rx_word, 24'h010300);
    check("retx_dv", dv_cnt, 6);
    check("retx_b1", dut.bright_q[1], 7'h55);
    check_duty("retx_duty", 64, 85, 0, 127);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
